// File: rtl/mult_unit.sv
// mult_unit: 8x8 multi-cycle shift-add multiplier, one iteration per clock.
// Define MUL_SIGNED_EN for a two's-complement multiply (sign-magnitude core).
module mult_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] OPERAND1,
    input  logic [7:0] OPERAND2,
    output logic [7:0] RESULT,
    output logic [7:0] RESULT_HI,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [8:0]  a;
    logic [2:0]  cnt;

    logic [8:0]  sum;
    logic [8:0]  a_nx;
    logic [7:0]  q_nx;
    logic [15:0] prod;
    logic        ovf;
    logic [7:0]  m_in;
    logic [7:0]  q_in;
    logic        accept;

`ifdef MUL_SIGNED_EN
    logic        sign;
    logic        sign_in;
`endif

    // One shift-add step, final product and operand conditioning
    always_comb begin
        sum    = q[0] ? ({1'b0, a[7:0]} + {1'b0, m}) : a;
        a_nx   = {1'b0, sum[8:1]};
        q_nx   = {sum[0], q[7:1]};
        accept = START && (state != S_RUN);
`ifdef MUL_SIGNED_EN
        m_in    = OPERAND1[7] ? (8'd0 - OPERAND1) : OPERAND1;
        q_in    = OPERAND2[7] ? (8'd0 - OPERAND2) : OPERAND2;
        sign_in = OPERAND1[7] ^ OPERAND2[7];
        prod    = sign ? (16'd0 - {a_nx[7:0], q_nx})
                       : {a_nx[7:0], q_nx};
        ovf     = prod[15:8] != {8{prod[7]}};
`else
        m_in    = OPERAND1;
        q_in    = OPERAND2;
        prod    = {a_nx[7:0], q_nx};
        ovf     = prod[15:8] != 8'd0;
`endif
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            m         <= 8'd0;
            q         <= 8'd0;
            a         <= 9'd0;
            cnt       <= 3'd0;
            RESULT    <= 8'd0;
            RESULT_HI <= 8'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERFLOW  <= 1'b0;
`ifdef MUL_SIGNED_EN
            sign      <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    DONE <= 1'b0;
                    if (accept) begin
                        m     <= m_in;
                        q     <= q_in;
                        a     <= 9'd0;
                        cnt   <= 3'd0;
                        BUSY  <= 1'b1;
                        state <= S_RUN;
`ifdef MUL_SIGNED_EN
                        sign  <= sign_in;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        RESULT_HI <= prod[15:8];
                        RESULT    <= prod[7:0];
                        OVERFLOW  <= ovf;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed-vector bench for mult_unit.
// Expectations follow MUL_SIGNED_EN in the same way as the design.
module tb_mult_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [7:0] OPERAND1;
    logic [7:0] OPERAND2;
    logic [7:0] RESULT;
    logic [7:0] RESULT_HI;
    logic       BUSY;
    logic       DONE;
    logic       OVERFLOW;

    int nvec = 0;
    int nerr = 0;

    mult_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OPERAND1  (OPERAND1),
        .OPERAND2  (OPERAND2),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Pulse START with operands, return edges from START edge to DONE
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          output int lat);
        @(negedge CLK);
        OPERAND1 = x;
        OPERAND2 = y;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        OPERAND1 = ~x;
        OPERAND2 = ~y;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        OPERAND1 = 8'h00;
        OPERAND2 = 8'h00;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nvec++;
        if ({RESULT, RESULT_HI, BUSY, DONE, OVERFLOW} !== 19'd0) begin
            nerr++;
            $display("FAIL reset_outputs got %h/%h b%b d%b o%b want 0",
                     RESULT, RESULT_HI, BUSY, DONE, OVERFLOW);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        @(negedge CLK);
        OPERAND1 = 8'd12;
        OPERAND2 = 8'd10;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        nvec++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            nerr++;
            $display("FAIL basic_busy got b%b d%b want b1 d0", BUSY, DONE);
        end
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
        nvec++;
        if (lat !== 8) begin
            nerr++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        nvec++;
        if (RESULT !== 8'h78 || RESULT_HI !== 8'h00 || OVERFLOW !== 1'b0
            || BUSY !== 1'b0) begin
            nerr++;
            $display("FAIL basic_12x10 got %h:%h o%b b%b want 00:78 o0 b0",
                     RESULT_HI, RESULT, OVERFLOW, BUSY);
        end
        @(posedge CLK);
        #1;
        nvec++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== 8'h78) begin
            nerr++;
            $display("FAIL basic_pulse got d%b b%b r%h want d0 b0 r78",
                     DONE, BUSY, RESULT);
        end
    endtask

    task automatic test_products();
        int lat;
        logic [7:0] xa [4];
        logic [7:0] ya [4];
        logic [16:0] ex [4];
        xa[0] = 8'hFF; ya[0] = 8'hFF;
        xa[1] = 8'h80; ya[1] = 8'h80;
        xa[2] = 8'hFD; ya[2] = 8'h05;
        xa[3] = 8'h80; ya[3] = 8'h02;
`ifdef MUL_SIGNED_EN
        ex[0] = {1'b0, 16'h0001};
        ex[1] = {1'b1, 16'h4000};
        ex[2] = {1'b0, 16'hFFF1};
        ex[3] = {1'b1, 16'hFF00};
`else
        ex[0] = {1'b1, 16'hFE01};
        ex[1] = {1'b1, 16'h4000};
        ex[2] = {1'b1, 16'h04F1};
        ex[3] = {1'b1, 16'h0100};
`endif
        for (int k = 0; k < 4; k++) begin
            run_op(xa[k], ya[k], lat);
            nvec++;
            if (lat !== 8 || {OVERFLOW, RESULT_HI, RESULT} !== ex[k]) begin
                nerr++;
                $display("FAIL product_%h_%h got o%b %h:%h lat %0d want %h",
                         xa[k], ya[k], OVERFLOW, RESULT_HI, RESULT, lat,
                         ex[k]);
            end
        end
    endtask

    task automatic test_start_held();
        int cnt;
        int extra;
        logic [16:0] ex;
`ifdef MUL_SIGNED_EN
        ex = {1'b1, 16'h008F};
`else
        ex = {1'b0, 16'h008F};
`endif
        @(negedge CLK);
        OPERAND1 = 8'h0B;
        OPERAND2 = 8'h0D;
        START    = 1'b1;
        @(posedge CLK);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            START    = (cnt < 5);
            OPERAND1 = 8'hF0 + 8'(i);
            OPERAND2 = 8'h3C ^ 8'(i);
            @(posedge CLK);
            #1;
            cnt++;
            if (DONE) break;
        end
        START = 1'b0;
        nvec++;
        if (cnt !== 8 || {OVERFLOW, RESULT_HI, RESULT} !== ex) begin
            nerr++;
            $display("FAIL held_start got o%b %h:%h at %0d want %h at 8",
                     OVERFLOW, RESULT_HI, RESULT, cnt, ex);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) extra++;
        end
        nvec++;
        if (extra !== 0) begin
            nerr++;
            $display("FAIL held_single_done got %0d extra cycles want 0",
                     extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(8'h03, 8'h04, lat);
        nvec++;
        if (lat !== 8 || RESULT !== 8'h0C || RESULT_HI !== 8'h00) begin
            nerr++;
            $display("FAIL b2b_first got %h:%h lat %0d want 00:0c lat 8",
                     RESULT_HI, RESULT, lat);
        end
        OPERAND1 = 8'h00;
        OPERAND2 = 8'hA5;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        nvec++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_busy got b%b d%b want b1 d0", BUSY, DONE);
        end
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
        nvec++;
        if (lat !== 9 || {OVERFLOW, RESULT_HI, RESULT} !== 17'd0) begin
            nerr++;
            $display("FAIL b2b_second got o%b %h:%h gap %0d want 0 gap 9",
                     OVERFLOW, RESULT_HI, RESULT, lat);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        run_op(8'h11, 8'h11, lat);
        nvec++;
        if (lat !== 8 || {OVERFLOW, RESULT_HI, RESULT} !== {1'b1, 16'h0121})
        begin
            nerr++;
            $display("FAIL abort_pre got o%b %h:%h want o1 01:21",
                     OVERFLOW, RESULT_HI, RESULT);
        end
        @(negedge CLK);
        OPERAND1 = 8'h05;
        OPERAND2 = 8'h06;
        START    = 1'b1;
        @(posedge CLK);
        seen = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            START = 1'b0;
            @(posedge CLK);
            #1;
            if (DONE) seen++;
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        nvec++;
        if ({RESULT, RESULT_HI, BUSY, DONE, OVERFLOW} !== 19'd0) begin
            nerr++;
            $display("FAIL abort_clear got %h/%h b%b d%b o%b want 0",
                     RESULT, RESULT_HI, BUSY, DONE, OVERFLOW);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen++;
        end
        nvec++;
        if (seen !== 0) begin
            nerr++;
            $display("FAIL abort_no_done got %0d want 0", seen);
        end
        run_op(8'd7, 8'd9, lat);
        nvec++;
        if (lat !== 8 || {OVERFLOW, RESULT_HI, RESULT} !== {1'b0, 16'h003F})
        begin
            nerr++;
            $display("FAIL abort_post_7x9 got o%b %h:%h lat %0d want 00:3f",
                     OVERFLOW, RESULT_HI, RESULT, lat);
        end
    endtask

    initial begin
        RESET    = 1'b0;
        START    = 1'b0;
        OPERAND1 = 8'h00;
        OPERAND2 = 8'h00;
        test_reset();
        test_basic();
        test_products();
        test_start_held();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
